// File: rtl/console_addr_qualifier.sv
// console_addr_qualifier: debounces the raw 2600 console address bus into a
// registered stable address, and turns UI hotspot reads into one-cycle events.
//
// Ports:
//   CLOCK_50      in   system clock, rising edge
//   RESET_N       in   synchronous reset, active-low
//   CONSOLE_ADDR  in   raw console address (13 bits, glitchy)
//   ENABLE        in   UI active; gates key and start events
//   STABLE_ADDR   out  last accepted address
//   ADDR_STROBE   out  one-cycle pulse when STABLE_ADDR takes a new value
//   KEY_INC/KEY_DEC/KEY_LEFT/KEY_RIGHT  out  one-cycle hotspot pulses
//   START_GAME    out  one-cycle pulse on a completed arm->start sequence
//
// DEBOUNCE_CYCLES is legal in 1..15. Hotspot addresses must be distinct.
module console_addr_qualifier #(
  parameter int unsigned DEBOUNCE_CYCLES = 2,
  parameter logic [12:0] INC_ADDR   = 13'h1150,
  parameter logic [12:0] DEC_ADDR   = 13'h1162,
  parameter logic [12:0] LEFT_ADDR  = 13'h1177,
  parameter logic [12:0] RIGHT_ADDR = 13'h1190,
  parameter logic [12:0] ARM_ADDR   = 13'h104C,
  parameter logic [12:0] START_ADDR = 13'h1FFC
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [12:0] CONSOLE_ADDR,
  input  logic        ENABLE,
  output logic [12:0] STABLE_ADDR,
  output logic        ADDR_STROBE,
  output logic        KEY_INC,
  output logic        KEY_DEC,
  output logic        KEY_LEFT,
  output logic        KEY_RIGHT,
  output logic        START_GAME
);

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [ADDR_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  logic              armed;

  logic              same_c;
  logic              accept_c;
  logic              new_addr_c;
  logic              fire_c;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              armed_nxt_c;

  // Debounce counting, acceptance detection and arm-state update.
  always_comb begin
    same_c      = (CONSOLE_ADDR == cand);
    // cnt saturates at CNT_SAT, so this fires once per stable run
    accept_c    = same_c && (cnt == CNT_LAST);
    new_addr_c  = accept_c && (cand != STABLE_ADDR);
    fire_c      = new_addr_c && ENABLE;

    cnt_nxt_c = cnt;
    if (!same_c) begin
      cnt_nxt_c = '0;
    end else if (cnt < CNT_SAT) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end

    // Arm state only moves on acceptance edges; anything but ARM disarms
    armed_nxt_c = armed;
    if (accept_c) begin
      armed_nxt_c = ENABLE && (cand == ARM_ADDR);
    end
  end

  // State and registered outputs; pulses default low on non-acceptance edges.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      cand        <= '0;
      cnt         <= '0;
      armed       <= 1'b0;
      STABLE_ADDR <= '0;
      ADDR_STROBE <= 1'b0;
      KEY_INC     <= 1'b0;
      KEY_DEC     <= 1'b0;
      KEY_LEFT    <= 1'b0;
      KEY_RIGHT   <= 1'b0;
      START_GAME  <= 1'b0;
    end else begin
      if (!same_c) begin
        cand <= CONSOLE_ADDR;
      end
      cnt   <= cnt_nxt_c;
      armed <= armed_nxt_c;
      if (new_addr_c) begin
        STABLE_ADDR <= cand;
      end
      ADDR_STROBE <= new_addr_c;
      KEY_INC     <= fire_c && (cand == INC_ADDR);
      KEY_DEC     <= fire_c && (cand == DEC_ADDR);
      KEY_LEFT    <= fire_c && (cand == LEFT_ADDR);
      KEY_RIGHT   <= fire_c && (cand == RIGHT_ADDR);
      START_GAME  <= fire_c && armed && (cand == START_ADDR);
    end
  end

endmodule
